// File: rtl/anc_pkg.sv
// Shared definitions for the ANC datapath: FIR engine state encoding and a width helper.
package anc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_OUT  = 2'd2
   } state_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/bw_mult.sv
// Combinational signed N x N multiplier producing the full 2N-bit two's complement product.
module bw_mult #(
   parameter int unsigned N = 16
) (
   input  logic signed [N-1:0]   a_i,
   input  logic signed [N-1:0]   b_i,
   output logic signed [2*N-1:0] p_o
);

   logic signed [2*N-1:0] a_ext;
   logic signed [2*N-1:0] b_ext;

   always_comb begin
      a_ext = {{N{a_i[N-1]}}, a_i};
      b_ext = {{N{b_i[N-1]}}, b_i};
      p_o   = a_ext * b_ext;
   end

endmodule

// File: rtl/anc_fir_mac.sv
// Time-multiplexed signed FIR: one tap per cycle through a single bw_mult, one result per sample.
module anc_fir_mac
   import anc_pkg::*;
#(
   parameter int unsigned  N     = 16,
   parameter int unsigned  TAPS  = 16,
   localparam int unsigned AW    = clog2(TAPS),
   localparam int unsigned ACC_W = 2 * N + clog2(TAPS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_sample,
   input  logic             coef_we,
   input  logic [AW-1:0]    coef_addr,
   input  logic [N-1:0]     coef_wdata,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic             busy
);

   // k runs one past the last tap; that extra MAC cycle transfers acc into out_data.
   localparam logic [AW:0] KDone = (AW + 1)'(TAPS);

   state_e           state_q, state_d;
   logic [AW:0]      k_q, k_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] out_q, out_d;
   logic [N-1:0]     x_q [TAPS];
   logic [N-1:0]     x_d [TAPS];
   logic [N-1:0]     c_q [TAPS];
   logic [N-1:0]     c_d [TAPS];

   logic [AW-1:0]         tap_sel;
   logic [N-1:0]          tap_x;
   logic [N-1:0]          tap_c;
   logic signed [2*N-1:0] prod;
   logic [ACC_W-1:0]      prod_ext;

   always_comb begin
      tap_sel  = (k_q == KDone) ? '0 : k_q[AW-1:0];
      tap_x    = x_q[tap_sel];
      tap_c    = c_q[tap_sel];
      prod_ext = {{(ACC_W - 2 * N){prod[2*N-1]}}, prod};
   end

   bw_mult #(
      .N(N)
   ) u_mult (
      .a_i(tap_x),
      .b_i(tap_c),
      .p_o(prod)
   );

   always_comb begin
      state_d   = state_q;
      k_d       = k_q;
      acc_d     = acc_q;
      out_d     = out_q;
      x_d       = x_q;
      c_d       = c_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (coef_we) c_d[coef_addr] = coef_wdata;
            if (in_valid) begin
               x_d[0] = in_sample;
               for (int i = 1; i < int'(TAPS); i++) x_d[i] = x_q[i-1];
               acc_d   = '0;
               k_d     = '0;
               state_d = ST_MAC;
            end
         end
         ST_MAC: begin
            busy = 1'b1;
            if (k_q == KDone) begin
               out_d   = acc_q;
               state_d = ST_OUT;
            end else begin
               acc_d = acc_q + prod_ext;
               k_d   = k_q + (AW + 1)'(1);
            end
         end
         ST_OUT: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         acc_q   <= '0;
         out_q   <= '0;
         for (int i = 0; i < int'(TAPS); i++) begin
            x_q[i] <= '0;
            c_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         acc_q   <= acc_d;
         out_q   <= out_d;
         x_q     <= x_d;
         c_q     <= c_d;
      end
   end

   assign out_data = out_q;

endmodule

// File: tb/tb_anc_fir_mac.sv
// Self-checking bench for anc_fir_mac: a 4-tap and a 16-tap instance against a sum-of-products model.
module tb_anc_fir_mac;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic [1:0]          in_valid, in_ready, coef_we, out_valid, out_ready, busy;
   logic [1:0][15:0]    in_sample, coef_wdata;
   logic [1:0][3:0]     coef_addr;
   logic [33:0]         out_data4;
   logic [35:0]         out_data16;
   logic [1:0][35:0]    out_data;

   assign out_data[0] = {2'b00, out_data4};
   assign out_data[1] = out_data16;

   anc_fir_mac #(.N(16), .TAPS(4)) u_dut4 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[0]),
      .in_ready   (in_ready[0]),
      .in_sample  (in_sample[0]),
      .coef_we    (coef_we[0]),
      .coef_addr  (coef_addr[0][1:0]),
      .coef_wdata (coef_wdata[0]),
      .out_valid  (out_valid[0]),
      .out_ready  (out_ready[0]),
      .out_data   (out_data4),
      .busy       (busy[0])
   );

   anc_fir_mac #(.N(16), .TAPS(16)) u_dut16 (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid[1]),
      .in_ready   (in_ready[1]),
      .in_sample  (in_sample[1]),
      .coef_we    (coef_we[1]),
      .coef_addr  (coef_addr[1]),
      .coef_wdata (coef_wdata[1]),
      .out_valid  (out_valid[1]),
      .out_ready  (out_ready[1]),
      .out_data   (out_data16),
      .busy       (busy[1])
   );

   int n_checks = 0;
   int n_fail   = 0;
   int c_m  [2][16];
   int hist [2][16];

   function automatic int taps_of(input int d);
      return (d == 0) ? 4 : 16;
   endfunction

   // y[n] = sum c[k]*x[n-k], reduced modulo 2^ACC_W
   function automatic logic [35:0] ref_y(input int d);
      longint s;
      s = 0;
      for (int k = 0; k < taps_of(d); k++) s += longint'(c_m[d][k]) * longint'(hist[d][k]);
      s = s & ((longint'(1) << ((d == 0) ? 34 : 36)) - 1);
      return s[35:0];
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < 16; k++) begin
            c_m[d][k]  = 0;
            hist[d][k] = 0;
         end
   endtask

   task automatic model_push(input int d, input logic [15:0] s);
      for (int k = taps_of(d) - 1; k > 0; k--) hist[d][k] = hist[d][k-1];
      hist[d][0] = int'($signed(s));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      in_valid = '0; coef_we = '0; out_ready = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic write_coef(input int d, input int a, input logic [15:0] v);
      @(negedge clk);
      coef_we[d] = 1'b1; coef_addr[d] = 4'(a); coef_wdata[d] = v;
      @(posedge clk);
      #1 coef_we[d] = 1'b0;
      c_m[d][a] = int'($signed(v));
   endtask

   // Accepts one sample, optionally strobes coef_we (addr 0, data 7) we_at cycles into MAC.
   task automatic send(input int d, input logic [15:0] s, input int we_at,
                       output logic [35:0] got, output int lat, output bit rdy_low);
      @(negedge clk);
      in_valid[d] = 1'b1; in_sample[d] = s;
      @(posedge clk);
      #1 in_valid[d] = 1'b0;
      coef_we[d] = 1'b0;
      model_push(d, s);
      lat = 0; rdy_low = 1'b1;
      while (lat < 60 && !out_valid[d]) begin
         if (in_ready[d]) rdy_low = 1'b0;
         if (lat == we_at) begin
            coef_we[d] = 1'b1; coef_addr[d] = '0; coef_wdata[d] = 16'd7;
         end
         @(posedge clk);
         #1 coef_we[d] = 1'b0;
         lat++;
      end
      got = out_data[d];
      out_ready[d] = 1'b1;
      @(posedge clk);
      #1 out_ready[d] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = '0; coef_we = '0; out_ready = '0; in_sample = '0; coef_wdata = '0; coef_addr = '0;
      model_reset();
      #12;
      for (int d = 0; d < 2; d++) begin
         n_checks++;
         if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || busy[d] !== 1'b0 ||
             out_data[d] !== 36'd0) begin
            n_fail++;
            $display("FAIL reset_state[%0d]: got rdy=%b vld=%b busy=%b data=%0h, want 1 0 0 0",
                     d, in_ready[d], out_valid[d], busy[d], out_data[d]);
         end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic();
      logic [35:0] got; int lat; bit rl;
      write_coef(0, 0, 16'd1);
      send(0, 16'd5, -1, got, lat, rl);
      n_checks++;
      if (got !== 36'd5) begin n_fail++; $display("FAIL basic_data: got %0h want 5", got); end
      n_checks++;
      if (lat !== 5) begin n_fail++; $display("FAIL basic_latency: got %0d want 5", lat); end
      n_checks++;
      if (rl !== 1'b1) begin n_fail++; $display("FAIL basic_in_ready_low: in_ready seen high in MAC"); end
   endtask

   task automatic test_sign();
      logic [35:0] got; int lat; bit rl;
      write_coef(0, 0, 16'hFFFD);
      send(0, 16'hFFF9, -1, got, lat, rl);
      n_checks++;
      if (got !== 36'd21) begin n_fail++; $display("FAIL sign_neg_neg: got %0h want 15", got); end
      write_coef(0, 0, 16'h8000);
      send(0, 16'h8000, -1, got, lat, rl);
      n_checks++;
      if (got !== 36'h0_4000_0000) begin
         n_fail++; $display("FAIL sign_min_min: got %0h want 40000000", got);
      end
   endtask

   task automatic test_delay_line();
      logic [35:0] got; int lat; bit rl;
      logic [15:0] stim [5];
      logic [35:0] want [5];
      stim = '{16'd1, 16'd0, 16'd0, 16'd0, 16'd0};
      want = '{36'd1, 36'd2, 36'd3, 36'd4, 36'd0};
      do_reset();
      for (int k = 0; k < 4; k++) write_coef(0, k, 16'(k + 1));
      for (int i = 0; i < 5; i++) begin
         send(0, stim[i], -1, got, lat, rl);
         n_checks++;
         if (got !== want[i]) begin
            n_fail++; $display("FAIL delay_line[%0d]: got %0h want %0h", i, got, want[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [35:0] got, exp; int lat, cyc; bit rl;
      logic [15:0] s;
      s = 16'($urandom);
      @(negedge clk);
      in_valid[0] = 1'b1; in_sample[0] = s;
      @(posedge clk);
      #1 in_valid[0] = 1'b0;
      model_push(0, s);
      exp = ref_y(0);
      cyc = 0;
      while (cyc < 60 && !out_valid[0]) begin
         @(posedge clk); #1; cyc++;
      end
      n_checks++;
      if (out_valid[0] !== 1'b1) begin n_fail++; $display("FAIL bp_reach_out: out_valid=0 want 1"); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid[0] = 1'b1; in_sample[0] = 16'h7FFF;
         @(posedge clk);
         #1 in_valid[0] = 1'b0;
         n_checks++;
         if (out_valid[0] !== 1'b1 || out_data[0] !== exp || in_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold[%0d]: got vld=%b data=%0h rdy=%b want 1 %0h 0",
                     i, out_valid[0], out_data[0], in_ready[0], exp);
         end
      end
      out_ready[0] = 1'b1;
      @(posedge clk);
      #1 out_ready[0] = 1'b0;
      n_checks++;
      if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
         n_fail++; $display("FAIL bp_release: got vld=%b rdy=%b want 0 1", out_valid[0], in_ready[0]);
      end
      send(0, 16'($urandom), -1, got, lat, rl);
      n_checks++;
      if (got !== ref_y(0)) begin
         n_fail++; $display("FAIL bp_ignored_in_valid: got %0h want %0h", got, ref_y(0));
      end
   endtask

   task automatic test_mac_drop_and_abort();
      logic [35:0] got; int lat, cyc; bit rl, seen;
      write_coef(0, 0, 16'd3);
      send(0, 16'($urandom), 2, got, lat, rl);
      n_checks++;
      if (got !== ref_y(0)) begin n_fail++; $display("FAIL drop_cur: got %0h want %0h", got, ref_y(0)); end
      send(0, 16'($urandom), -1, got, lat, rl);
      n_checks++;
      if (got !== ref_y(0)) begin n_fail++; $display("FAIL drop_next: got %0h want %0h", got, ref_y(0)); end

      for (int k = 0; k < 4; k++) write_coef(0, k, (k == 0) ? 16'd9 : 16'(k + 4));
      @(negedge clk);
      in_valid[0] = 1'b1; in_sample[0] = 16'd3;
      @(posedge clk);
      #1 in_valid[0] = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      #2;
      n_checks++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || busy[0] !== 1'b0) begin
         n_fail++; $display("FAIL abort_state: got rdy=%b vld=%b busy=%b want 1 0 0",
                            in_ready[0], out_valid[0], busy[0]);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (cyc = 0; cyc < 8; cyc++) begin
         @(posedge clk); #1;
         if (out_valid[0]) seen = 1'b1;
      end
      n_checks++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_output: out_valid=1 want 0"); end
      for (int k = 0; k < 4; k++) write_coef(0, k, (k == 0) ? 16'd9 : 16'(k + 4));
      send(0, 16'd1, -1, got, lat, rl);
      n_checks++;
      if (got !== 36'd9) begin n_fail++; $display("FAIL abort_line_cleared: got %0h want 9", got); end
   endtask

   task automatic test_same_cycle_write();
      logic [35:0] got; int lat; bit rl;
      logic [15:0] v;
      v = 16'($urandom);
      @(negedge clk);
      coef_we[0] = 1'b1; coef_addr[0] = 4'd1; coef_wdata[0] = v;
      c_m[0][1] = int'($signed(v));
      send(0, 16'($urandom), -1, got, lat, rl);
      n_checks++;
      if (got !== ref_y(0)) begin n_fail++; $display("FAIL same_cycle_we: got %0h want %0h", got, ref_y(0)); end
   endtask

   task automatic test_random4();
      logic [35:0] got; int lat; bit rl;
      for (int i = 0; i < 12; i++) begin
         if ($urandom_range(0, 1) == 1) write_coef(0, int'($urandom_range(0, 3)), 16'($urandom));
         send(0, 16'($urandom), -1, got, lat, rl);
         n_checks++;
         if (got !== ref_y(0)) begin
            n_fail++; $display("FAIL random4[%0d]: got %0h want %0h", i, got, ref_y(0));
         end
      end
   endtask

   task automatic test_taps16();
      logic [35:0] got; int lat; bit rl;
      for (int k = 0; k < 16; k++) write_coef(1, k, 16'h8000);
      for (int i = 0; i < 16; i++) begin
         send(1, 16'h8000, -1, got, lat, rl);
         if (i == 0) begin
            n_checks++;
            if (lat !== 17) begin n_fail++; $display("FAIL t16_latency: got %0d want 17", lat); end
         end
         n_checks++;
         if (got !== ref_y(1)) begin
            n_fail++; $display("FAIL t16_fill[%0d]: got %0h want %0h", i, got, ref_y(1));
         end
      end
      n_checks++;
      if (got !== 36'h4_0000_0000) begin n_fail++; $display("FAIL t16_max: got %0h want 400000000", got); end
      for (int k = 0; k < 16; k++) write_coef(1, k, 16'($urandom));
      for (int i = 0; i < 10; i++) begin
         send(1, 16'($urandom), -1, got, lat, rl);
         n_checks++;
         if (got !== ref_y(1)) begin
            n_fail++; $display("FAIL t16_random[%0d]: got %0h want %0h", i, got, ref_y(1));
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_basic();
      test_sign();
      test_delay_line();
      test_backpressure();
      test_mac_drop_and_abort();
      test_same_cycle_write();
      test_random4();
      test_taps16();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
